// File: rtl/pkt_xmit_if.sv
// pkt_xmit_if: write-side handshake and serial-line bundle for pkt_xmit.
//   data_in  : byte offered for transmission
//   writing  : one-cycle write strobe
//   ready    : holding register empty, a write will be accepted
//   overrun  : sticky, a write was dropped because the holding register was full
//   busy     : a frame (header, body or gap) is in progress
//   data_out : registered serial line towards the header-matching receiver
// master = the byte producer, slave = the transmitter.
interface pkt_xmit_if;
  logic [7:0] data_in;
  logic       writing;
  logic       ready;
  logic       overrun;
  logic       busy;
  logic       data_out;

  modport master (
    output data_in, writing,
    input  ready, overrun, busy, data_out
  );

  modport slave (
    input  data_in, writing,
    output ready, overrun, busy, data_out
  );
endinterface

// File: rtl/pkt_xmit.sv
// pkt_xmit: serial packet transmitter.
// Each accepted byte goes through a single-entry holding register into a
// 16-bit shifter and leaves as {MATCH, byte}, MSB first, one bit per clock,
// followed by GAP idle zeros. The line idles at 0 between frames.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pkt_xmit_if.slave (data_in, writing in; ready, overrun, busy,
//           data_out out). All outputs come straight from flops.
module pkt_xmit #(
  parameter logic [7:0]  MATCH = 8'hA5,
  parameter int unsigned GAP   = 1
) (
  input logic      clock,
  input logic      reset,
  pkt_xmit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_GAP} state_t;

  // Only meaningful when GAP > 0; the S_GAP state is unreachable otherwise.
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state, state_n;
  logic [15:0] shift, shift_n;
  logic [7:0]  hold, hold_n;
  logic        ready, ready_n;
  logic        overrun, overrun_n;
  logic        busy, busy_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [3:0]  gapcnt, gapcnt_n;
  logic        load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shift   <= '0;
      hold    <= '0;
      ready   <= 1'b1;
      overrun <= 1'b0;
      busy    <= 1'b0;
      bitcnt  <= '0;
      gapcnt  <= '0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      hold    <= hold_n;
      ready   <= ready_n;
      overrun <= overrun_n;
      busy    <= busy_n;
      bitcnt  <= bitcnt_n;
      gapcnt  <= gapcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    hold_n    = hold;
    ready_n   = ready;
    overrun_n = overrun;
    busy_n    = busy;
    bitcnt_n  = bitcnt;
    gapcnt_n  = gapcnt;
    load      = 1'b0;

    // Holding register: ready doubles as "hold empty".
    if (bus.writing) begin
      if (ready) begin
        hold_n    = bus.data_in;
        ready_n   = 1'b0;
        overrun_n = 1'b0;
      end else begin
        overrun_n = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (!ready) load = 1'b1;
      end
      S_HEAD: begin
        // Zeros shift in from the bottom, so after 16 shifts the line is 0.
        shift_n = {shift[14:0], 1'b0};
        if (bitcnt == 3'd7) begin
          state_n  = S_BODY;
          bitcnt_n = '0;
        end else begin
          bitcnt_n = bitcnt + 3'd1;
        end
      end
      S_BODY: begin
        shift_n = {shift[14:0], 1'b0};
        if (bitcnt == 3'd7) begin
          bitcnt_n = '0;
          if (GAP != 0) begin
            state_n  = S_GAP;
            gapcnt_n = '0;
          end else if (!ready) begin
            load = 1'b1;
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          bitcnt_n = bitcnt + 3'd1;
        end
      end
      S_GAP: begin
        if (gapcnt == GAP_LAST) begin
          if (!ready) begin
            load = 1'b1;
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          gapcnt_n = gapcnt + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Transfer only happens with the hold full, hence ready=0, so it can never
    // collide with an accepted write; it may coincide with an overrun.
    if (load) begin
      shift_n  = {MATCH, hold};
      ready_n  = 1'b1;
      busy_n   = 1'b1;
      state_n  = S_HEAD;
      bitcnt_n = '0;
      gapcnt_n = '0;
    end
  end

  // The top shifter bit is the line itself, so data_out is a flop output.
  assign bus.data_out = shift[15];
  assign bus.ready    = ready;
  assign bus.overrun  = overrun;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_pkt_xmit.sv
// tb_pkt_xmit: bench for pkt_xmit. Two instances share one stimulus stream,
// one with GAP=0 and one with GAP=1. A frame-level model (pending-bit list
// plus holding-register flag) predicts every output each cycle, and a simple
// header-matching receiver decodes each DUT line and compares recovered bytes
// with the bytes the model framed.
module tb_pkt_xmit;
  localparam logic [7:0] MATCH = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       writing = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clock = ~clock;

  pkt_xmit_if bus0 ();
  pkt_xmit_if bus1 ();

  assign bus0.writing = writing;
  assign bus0.data_in = din;
  assign bus1.writing = writing;
  assign bus1.data_in = din;

  pkt_xmit #(.MATCH(MATCH), .GAP(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  pkt_xmit #(.MATCH(MATCH), .GAP(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  logic [1:0] o_do, o_busy, o_rdy, o_ovr;
  assign o_do   = {bus1.data_out, bus0.data_out};
  assign o_busy = {bus1.busy,     bus0.busy};
  assign o_rdy  = {bus1.ready,    bus0.ready};
  assign o_ovr  = {bus1.overrun,  bus0.overrun};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state, index d = instance (its GAP equals d).
  logic        m_full [2];
  logic [7:0]  m_hold [2];
  logic        m_ovr  [2];
  logic        m_do   [2];
  logic        m_busy [2];
  logic [31:0] m_pend [2];
  int          m_npend[2];

  logic [7:0]  exp_mem[2][1024];
  int          exp_wr [2];
  int          exp_rd [2];

  // Receiver model.
  logic [7:0]  rx_win [2];
  logic [7:0]  rx_sh  [2];
  int          rx_cnt [2];
  logic        rx_body[2];
  logic [7:0]  rx_log [2][1024];
  int          rx_n   [2];

  logic        hist_do  [2][4096];
  logic        hist_busy[2][4096];

  function automatic int gap_of(input int d);
    return d;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, want %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic rx_clear(input int d);
    rx_win[d]  = '0;
    rx_sh[d]   = '0;
    rx_cnt[d]  = 0;
    rx_body[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_full[d]  = 1'b0;
      m_hold[d]  = '0;
      m_ovr[d]   = 1'b0;
      m_do[d]    = 1'b0;
      m_busy[d]  = 1'b0;
      m_pend[d]  = '0;
      m_npend[d] = 0;
      exp_rd[d]  = exp_wr[d];
      rx_clear(d);
    end
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_step();
    logic rdy;
    for (int d = 0; d < 2; d++) begin
      rdy = !m_full[d];
      if (m_npend[d] > 0) begin
        m_npend[d]--;
        m_do[d]   = m_pend[d][m_npend[d]];
        m_busy[d] = 1'b1;
      end else if (m_full[d]) begin
        m_pend[d]  = {16'h0, MATCH, m_hold[d]} << gap_of(d);
        m_npend[d] = 15 + gap_of(d);
        m_do[d]    = m_pend[d][m_npend[d]];
        m_busy[d]  = 1'b1;
        m_full[d]  = 1'b0;
        exp_mem[d][exp_wr[d]] = m_hold[d];
        exp_wr[d]++;
      end else begin
        m_do[d]   = 1'b0;
        m_busy[d] = 1'b0;
      end
      if (writing) begin
        if (rdy) begin
          m_hold[d] = din;
          m_full[d] = 1'b1;
          m_ovr[d]  = 1'b0;
        end else begin
          m_ovr[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic rx_step(input int d, input logic b);
    if (rx_body[d]) begin
      rx_sh[d] = {rx_sh[d][6:0], b};
      rx_cnt[d]++;
      if (rx_cnt[d] == 8) begin
        rx_log[d][rx_n[d]] = rx_sh[d];
        rx_n[d]++;
        if (exp_rd[d] < exp_wr[d]) begin
          chk("rx_byte", d, rx_sh[d], exp_mem[d][exp_rd[d]]);
          exp_rd[d]++;
        end else begin
          checks++;
          errors++;
          $display("FAIL rx_extra dut%0d: got byte %0h, want none", d, rx_sh[d]);
        end
        rx_clear(d);
      end
    end else begin
      rx_win[d] = {rx_win[d][6:0], b};
      if (rx_cnt[d] < 8) rx_cnt[d]++;
      if (rx_cnt[d] == 8 && rx_win[d] == MATCH) begin
        rx_body[d] = 1'b1;
        rx_cnt[d]  = 0;
      end
    end
  endtask

  task automatic observe();
    for (int d = 0; d < 2; d++) begin
      chk("data_out", d, o_do[d],   m_do[d]);
      chk("busy",     d, o_busy[d], m_busy[d]);
      chk("ready",    d, o_rdy[d],  !m_full[d]);
      chk("overrun",  d, o_ovr[d],  m_ovr[d]);
      if (reset) rx_clear(d);
      else       rx_step(d, o_do[d]);
      if (cyc < 4096) begin
        hist_do[d][cyc]   = o_do[d];
        hist_busy[d][cyc] = o_busy[d];
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (!reset) model_step();
    @(negedge clock);
    observe();
  endtask

  task automatic write_byte(input logic [7:0] b);
    writing = 1'b1;
    din     = b;
    tick();
    writing = 1'b0;
  endtask

  function automatic logic [63:0] seq(input int d, input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], hist_do[d][from + i]};
    return v;
  endfunction

  // k = 1 is the most recent byte; 9'h100 flags "nothing received".
  function automatic logic [8:0] rx_back(input int d, input int k);
    if (rx_n[d] >= k) return {1'b0, rx_log[d][rx_n[d] - k]};
    return 9'h100;
  endfunction

  initial begin
    int e0;
    int n;
    int r0 [2];
    logic bad [2];
    logic [63:0] expv;

    for (int d = 0; d < 2; d++) begin
      exp_wr[d] = 0;
      rx_n[d]   = 0;
    end
    model_reset();

    // Reset state.
    reset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready",    d, o_rdy[d],  1'b1);
      chk("rst_data_out", d, o_do[d],   1'b0);
      chk("rst_busy",     d, o_busy[d], 1'b0);
      chk("rst_overrun",  d, o_ovr[d],  1'b0);
    end
    reset = 1'b0;
    repeat (2) tick();

    // Single write.
    write_byte(8'h3C);
    e0 = cyc;
    repeat (20) tick();
    for (int d = 0; d < 2; d++) begin
      chk("frame_3c", d, seq(d, e0 + 1, 17), 64'({16'hA53C, 1'b0}));
      chk("rx_3c",    d, rx_back(d, 1), 9'h03C);
    end

    // Second write while the first frame is shifting.
    write_byte(8'h01);
    e0 = cyc;
    repeat (2) tick();
    write_byte(8'hFF);
    repeat (45) tick();
    expv = 64'({8'hA5, 8'h01, 1'b0, 8'hA5, 8'hFF, 1'b0});
    chk("two_frames_gap1", 1, seq(1, e0 + 1, 34), expv);
    expv = 64'({8'hA5, 8'h01, 8'hA5, 8'hFF, 1'b0});
    chk("two_frames_gap0", 0, seq(0, e0 + 1, 33), expv);
    for (int d = 0; d < 2; d++) begin
      chk("rx_01", d, rx_back(d, 2), 9'h001);
      chk("rx_ff", d, rx_back(d, 1), 9'h0FF);
      chk("no_overrun", d, o_ovr[d], 1'b0);
    end

    // Write while ready=0.
    writing = 1'b1;
    din     = 8'h11;
    tick();
    din     = 8'h22;
    tick();
    writing = 1'b0;
    for (int d = 0; d < 2; d++) chk("overrun_set", d, o_ovr[d], 1'b1);
    repeat (40) tick();
    for (int d = 0; d < 2; d++) chk("rx_11_not_22", d, rx_back(d, 1), 9'h011);
    write_byte(8'h33);
    for (int d = 0; d < 2; d++) chk("overrun_clear", d, o_ovr[d], 1'b0);
    repeat (25) tick();
    for (int d = 0; d < 2; d++) chk("rx_33", d, rx_back(d, 1), 9'h033);

    // Hold kept full on the GAP=0 instance: three contiguous frames.
    write_byte(8'hA5);
    e0 = cyc;
    tick();
    write_byte(8'h5A);
    n = 0;
    while (!o_rdy[0] && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", 0, n < 40, 1'b1);
    write_byte(8'h00);
    repeat (60) tick();
    expv = 64'({8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'h00, 1'b0});
    chk("contig_48", 0, seq(0, e0 + 1, 49), expv);
    chk("rx_a5", 0, rx_back(0, 3), 9'h0A5);
    chk("rx_5a", 0, rx_back(0, 2), 9'h05A);
    chk("rx_00", 0, rx_back(0, 1), 9'h000);

    // Idle line.
    for (int d = 0; d < 2; d++) begin
      r0[d]  = rx_n[d];
      bad[d] = 1'b0;
    end
    repeat (100) begin
      tick();
      for (int d = 0; d < 2; d++) if (o_do[d] || o_busy[d]) bad[d] = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      chk("idle_line", d, bad[d], 1'b0);
      chk("idle_rx",   d, rx_n[d], r0[d]);
    end

    // Random traffic.
    repeat (800) begin
      writing = ($urandom_range(0, 2) == 0);
      din     = 8'($urandom);
      tick();
    end
    writing = 1'b0;
    repeat (40) tick();

    // Reset in the middle of a body.
    writing = 1'b1;
    din     = 8'hC3;
    tick();
    din     = 8'h99;
    tick();
    writing = 1'b0;
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_data_out", d, o_do[d],   1'b0);
      chk("arst_ready",    d, o_rdy[d],  1'b1);
      chk("arst_busy",     d, o_busy[d], 1'b0);
      chk("arst_overrun",  d, o_ovr[d],  1'b0);
    end
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) r0[d] = rx_n[d];
    write_byte(8'h3C);
    repeat (25) tick();
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_rx",    d, rx_back(d, 1), 9'h03C);
      chk("post_rst_count", d, rx_n[d], r0[d] + 1);
      chk("exp_drained",    d, exp_wr[d] - exp_rd[d], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_xmit.md
Name: pkt_xmit

Overview:
- Serial packet transmitter that sits directly upstream of the header-matching serial receiver and drives that receiver's data_in line.
- Accepts one byte per write through a single-entry holding register and serialises it as a 16-bit frame: an 8-bit header MATCH, then 8 body bits, both MSB first, one bit per clock.
- Between frames it drives the line idle at 0.
- Because the line idles at 0, the receiver waits in its first header state and does not false-trigger while the transmitter is idle.

Parameters:
- MATCH, 8'hA5, frame header. Must equal the receiver's hard-coded header.
- GAP, 1, number of idle 0 bits inserted after each frame before the next header. Legal range 0..15; 0 means back-to-back frames.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only when writing=1 and ready=1.
- writing  input  1  write strobe, one cycle per byte.
- ready  output  1  holding register empty, so a write will be accepted.
- overrun  output  1  sticky flag: a write was attempted while ready=0 and its byte was dropped.
- busy  output  1  a frame (header, body or gap) is in progress.
- data_out  output  1  serial line to the receiver; registered.

Behaviour:
- Reset (async, any time, including mid-frame):
  - FSM goes to IDLE; holding register empties.
  - Outputs: data_out=0, ready=1, overrun=0, busy=0.
  - Shift register and bit counter clear to 0.
  - A frame in flight is abandoned. The receiver resynchronises on the next header.
- All outputs are registered. No combinational path from inputs to outputs.
- Write handshake:
  - writing=1 && ready=1 at edge E0: hold<=data_in, ready<=0, overrun<=0.
  - writing=1 && ready=0: byte discarded, overrun<=1. hold, ready and the FSM are unaffected.
  - overrun stays set until the next accepted write or reset.
- Transfer from hold to shifter: at any edge where the hold is full and the FSM is in IDLE (or at the last GAP bit, or the last BODY bit when GAP=0):
  - shift register <= {MATCH, hold}.
  - ready<=1 on that same edge.
  - A write on the following cycle is therefore accepted while the frame is shifting (double buffering).
- FSM states: IDLE, HEAD, BODY, GAP.
  - 3-bit bit counter, and a 4-bit counter for GAP.
- Transitions:
  - IDLE -> HEAD on transfer. data_out<=MATCH[7], busy<=1.
  - HEAD: shift one bit per clock. After header bit 0 -> BODY.
  - BODY: shift hold bits 7..0. After body bit 0:
    - GAP>0: -> GAP, data_out<=0.
    - GAP=0 and hold full: transfer, -> HEAD.
    - GAP=0 and hold empty: -> IDLE, data_out<=0, busy<=0.
  - GAP: data_out=0 for exactly GAP cycles. Then transfer to HEAD if hold full, else -> IDLE, busy<=0.
- Latency, isolated write accepted at E0:
  - data_out carries header bit 7 from E1 and body bit 0 during cycle E16.
  - data_out returns to 0 at E17.
  - busy is 1 from E1 through the end of the gap (E17+GAP).
- Throughput: one frame per 16+GAP cycles.
- A write accepted during a frame starts its header exactly after the current gap, with no extra idle cycle.
- Simultaneous transfer and write: impossible by construction, because ready=0 whenever the hold is full. A write in the cycle before ready rises reports overrun.
- Frame contents are independent of body data. Body bytes equal to MATCH need no special handling, because the receiver returns to header search only after 8 body bits.

Test Plan:
- Reset mid-body: assert reset while in BODY -> data_out=0, ready=1, busy=0, overrun=0 immediately, without waiting for a clock edge. The next write of 8'h3C then sends a full frame.
- Single write 8'h3C, GAP=1 -> data_out sequence from E1 is 1010010100111100, then 0. Receiver model shows ready=1 and data_out=8'h3C.
- Two writes, 8'h01 then 8'hFF, the second issued while the first frame is shifting -> frames separated by exactly 1 idle bit. Receiver captures 8'h01 then 8'hFF, overrun=0.
- Write while ready=0 (second write in the cycle after the first) -> overrun=1 and that byte is dropped. The next accepted write clears overrun.
- GAP=0 with the hold kept full, bytes 8'hA5, 8'h5A, 8'h00 -> 48 contiguous bits with no idle. Receiver decodes all three bytes, including a body equal to MATCH.
- Idle line for 100 cycles with no writes -> data_out=0, busy=0 throughout. Receiver never asserts ready.
